// File: rtl/ray_pkg.sv
// Shared types and helpers for the voxel ray stepper.
package ray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } stepper_state_e;

  typedef enum logic [1:0] {
    AXIS_NONE = 2'd0,
    AXIS_X    = 2'd1,
    AXIS_Y    = 2'd2,
    AXIS_Z    = 2'd3
  } axis_e;

  // Widest tMax supported by sat_add; callers zero-extend into this width.
  localparam int unsigned SAT_W = 64;

  // Unsigned add of two w-bit values (w < SAT_W) clamped to the w-bit all-ones value.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W-1:0] lim;
    logic [SAT_W-1:0] sum;
    lim = ~({SAT_W{1'b1}} << w);
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/voxel_ray_stepper_if.sv
// Occupancy-memory read port: address/strobe out, data back one cycle later.
interface voxel_ray_stepper_if #(
  parameter int unsigned X_BITS = 5,
  parameter int unsigned Y_BITS = 5,
  parameter int unsigned Z_BITS = 5
);
  logic              occ_rd_en;
  logic [X_BITS-1:0] occ_x;
  logic [Y_BITS-1:0] occ_y;
  logic [Z_BITS-1:0] occ_z;
  logic              occ_data;

  modport master (output occ_rd_en, occ_x, occ_y, occ_z, input occ_data);
  modport slave  (input occ_rd_en, occ_x, occ_y, occ_z, output occ_data);
endinterface

// File: rtl/dda_axis_sel.sv
// Picks the axis with the smallest tMax; ties go X, then Y, then Z.
module dda_axis_sel
  import ray_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] t_x,
  input  logic [W-1:0] t_y,
  input  logic [W-1:0] t_z,
  output axis_e        sel
);

  // Three-way minimum with fixed tie priority
  always_comb begin
    sel = AXIS_Z;
    if ((t_x <= t_y) && (t_x <= t_z)) sel = AXIS_X;
    else if (t_y <= t_z)              sel = AXIS_Y;
  end

endmodule

// File: rtl/voxel_ray_stepper.sv
// 3D DDA voxel traversal: one voxel per QUERY/EVAL pair against an occupancy memory.
module voxel_ray_stepper
  import ray_pkg::*;
#(
  parameter int unsigned X_BITS         = 5,
  parameter int unsigned Y_BITS         = 5,
  parameter int unsigned Z_BITS         = 5,
  parameter int unsigned W              = 24,
  parameter int unsigned MAX_STEPS_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_loaded,
  input  logic [X_BITS-1:0]         ix0_q,
  input  logic [Y_BITS-1:0]         iy0_q,
  input  logic [Z_BITS-1:0]         iz0_q,
  input  logic                      sx_q,
  input  logic                      sy_q,
  input  logic                      sz_q,
  input  logic [W-1:0]              next_x_q,
  input  logic [W-1:0]              next_y_q,
  input  logic [W-1:0]              next_z_q,
  input  logic [W-1:0]              inc_x_q,
  input  logic [W-1:0]              inc_y_q,
  input  logic [W-1:0]              inc_z_q,
  input  logic [MAX_STEPS_BITS-1:0] max_steps_q,
  voxel_ray_stepper_if.master       occ,
  output logic                      busy,
  output logic                      result_valid,
  output logic                      hit,
  output logic [X_BITS-1:0]         hit_x,
  output logic [Y_BITS-1:0]         hit_y,
  output logic [Z_BITS-1:0]         hit_z,
  output logic [1:0]                hit_face,
  output logic [MAX_STEPS_BITS-1:0] steps,
  output logic                      job_done
);

  stepper_state_e            state, state_nxt;
  logic [X_BITS-1:0]         cur_x;
  logic [Y_BITS-1:0]         cur_y;
  logic [Z_BITS-1:0]         cur_z;
  logic                      sgn_x, sgn_y, sgn_z;
  logic [W-1:0]              t_x, t_y, t_z;
  logic [W-1:0]              d_x, d_y, d_z;
  logic [MAX_STEPS_BITS-1:0] limit;
  logic [MAX_STEPS_BITS-1:0] step_cnt;
  axis_e                     face;
  axis_e                     sel;
  logic                      at_limit;
  logic                      leaves_grid;
  logic                      take_step;
  logic                      finish;

  dda_axis_sel #(.W(W)) u_sel (
    .t_x (t_x),
    .t_y (t_y),
    .t_z (t_z),
    .sel (sel)
  );

  // Address comes straight from the voxel register, which only changes on entry to QUERY
  assign occ.occ_x = cur_x;
  assign occ.occ_y = cur_y;
  assign occ.occ_z = cur_z;
  assign at_limit  = (step_cnt == limit);

  // Would a step on the selected axis fall off the grid edge
  always_comb begin
    leaves_grid = 1'b0;
    case (sel)
      AXIS_X:  leaves_grid = sgn_x ? (&cur_x) : ~(|cur_x);
      AXIS_Y:  leaves_grid = sgn_y ? (&cur_y) : ~(|cur_y);
      AXIS_Z:  leaves_grid = sgn_z ? (&cur_z) : ~(|cur_z);
      default: leaves_grid = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    occ.occ_rd_en = 1'b0;
    result_valid  = 1'b0;
    job_done      = 1'b0;
    take_step     = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: if (job_loaded) state_nxt = QUERY;
      QUERY: begin
        busy          = 1'b1;
        occ.occ_rd_en = 1'b1;
        state_nxt     = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (occ.occ_data || at_limit || leaves_grid) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          take_step = 1'b1;
          state_nxt = QUERY;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        job_done     = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job capture, DDA stepping and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x    <= '0;
      cur_y    <= '0;
      cur_z    <= '0;
      sgn_x    <= 1'b0;
      sgn_y    <= 1'b0;
      sgn_z    <= 1'b0;
      t_x      <= '0;
      t_y      <= '0;
      t_z      <= '0;
      d_x      <= '0;
      d_y      <= '0;
      d_z      <= '0;
      limit    <= '0;
      step_cnt <= '0;
      face     <= AXIS_NONE;
      hit      <= 1'b0;
      hit_x    <= '0;
      hit_y    <= '0;
      hit_z    <= '0;
      hit_face <= '0;
      steps    <= '0;
    end else begin
      if ((state == IDLE) && job_loaded) begin
        cur_x    <= ix0_q;
        cur_y    <= iy0_q;
        cur_z    <= iz0_q;
        sgn_x    <= sx_q;
        sgn_y    <= sy_q;
        sgn_z    <= sz_q;
        t_x      <= next_x_q;
        t_y      <= next_y_q;
        t_z      <= next_z_q;
        d_x      <= inc_x_q;
        d_y      <= inc_y_q;
        d_z      <= inc_z_q;
        limit    <= max_steps_q;
        step_cnt <= '0;
        face     <= AXIS_NONE;
      end
      if (take_step) begin
        step_cnt <= step_cnt + MAX_STEPS_BITS'(1);
        face     <= sel;
        case (sel)
          AXIS_X: begin
            cur_x <= sgn_x ? cur_x + X_BITS'(1) : cur_x - X_BITS'(1);
            t_x   <= W'(sat_add(SAT_W'(t_x), SAT_W'(d_x), W));
          end
          AXIS_Y: begin
            cur_y <= sgn_y ? cur_y + Y_BITS'(1) : cur_y - Y_BITS'(1);
            t_y   <= W'(sat_add(SAT_W'(t_y), SAT_W'(d_y), W));
          end
          AXIS_Z: begin
            cur_z <= sgn_z ? cur_z + Z_BITS'(1) : cur_z - Z_BITS'(1);
            t_z   <= W'(sat_add(SAT_W'(t_z), SAT_W'(d_z), W));
          end
          default: ;
        endcase
      end
      if (finish) begin
        hit      <= occ.occ_data;
        hit_x    <= cur_x;
        hit_y    <= cur_y;
        hit_z    <= cur_z;
        hit_face <= face;
        steps    <= step_cnt;
      end
    end
  end

endmodule
